grant_bus_mux: RTL and testbench
================================

# grant_bus_mux

Downstream consumer of the 4-requester round-robin arbiter's one-hot `grant`. It latches the granted requester as bus owner and muxes that requester's valid/ready data stream onto a single shared output bus through a registered stage. It holds ownership until the burst's last beat is accepted or a beat limit forces termination, then pulses `release` so the arbiter's next grant can be taken.

## Interface
Parameters:
- `DATA_W`, 8: data width per requester and on the output bus.
- `MAX_BEATS`, 4: maximum beats per ownership period; range 1..255.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `grant`  in  4  one-hot grant from the arbiter; bit i means requester i.
- `src_valid`  in  4  per-requester data valid.
- `src_data`  in  4*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- `src_last`  in  4  per-requester end-of-burst marker.
- `src_ready`  out  4  per-requester ready; only the owner's bit can be 1.
- `bus_valid`  out  1  registered output valid.
- `bus_data`  out  DATA_W  registered output data.
- `bus_id`  out  2  index of the requester that produced the beat.
- `bus_last`  out  1  last beat of the ownership period.
- `bus_ready`  in  1  downstream ready.
- `release`  out  1  one-cycle pulse when ownership ends.
- `err_multi`  out  1  one-cycle pulse when a multi-hot grant is sampled in IDLE.

## Operation
State machine with states IDLE, XFER and DRAIN.

IDLE:
- `src_ready` = 0.
- `grant` is sampled every cycle.
- Exactly one bit set: latch `owner` = its index, clear `beat_cnt`, go to XFER.
- Two or more bits set: pulse `err_multi`, stay in IDLE.
- All zero: stay in IDLE.

XFER:
- `src_ready[owner] = !bus_valid || bus_ready`. All other `src_ready` bits are 0.
- Accept condition: `src_valid[owner] && src_ready[owner]`.
- On accept, load `bus_data`, `bus_id` = owner, `bus_valid` = 1, and `bus_last = src_last[owner] || (beat_cnt == MAX_BEATS-1)`. Increment `beat_cnt`; its width is 8 bits.
- An accept with `bus_last` = 1 goes to DRAIN.
- Changes on `grant` are ignored while in XFER.

Output register:
- Clears `bus_valid` when `bus_valid && bus_ready` and no new accept occurs in the same cycle.
- Holds `bus_data`, `bus_id` and `bus_last` stable while `bus_valid && !bus_ready`.

DRAIN:
- `src_ready` = 0.
- Once the last beat handshakes (`bus_valid && bus_ready`), pulse `release` and go to IDLE.

Reset:
- Asserting `reset_n` low at any point forces IDLE.
- Clears `owner`, `beat_cnt` and all outputs to 0.
- Any in-flight beat is discarded, with no `release` pulse.

## Timing
- Reset values: `src_ready`=0, `bus_valid`=0, `bus_data`=0, `bus_id`=0, `bus_last`=0, `release`=0, `err_multi`=0.
- Grant to ownership: a one-hot grant sampled on edge N gives XFER from edge N. `src_ready[owner]` can first be high in cycle N+1.
- Data latency: a beat accepted on edge M appears on `bus_valid`/`bus_data` after edge M.
- Throughput: with `bus_ready` held high, one beat per cycle. The output register is a single stage with back-to-back replace.
- Backpressure: `src_ready[owner]` follows `bus_ready` combinationally while `bus_valid`=1. There is no combinational path from `src_valid` to `src_ready`.
- Release: a last beat accepted on edge M with `bus_ready`=1 handshakes on edge M+1. `release` is high during the cycle after edge M+1 and FSM is IDLE then.
- Minimum ownership period: 3 cycles, IDLE→XFER→DRAIN→IDLE.
- The arbiter may present a new grant during the `release` cycle. It is sampled because FSM is already IDLE.
- `MAX_BEATS`=1: every beat is forced last.
- `beat_cnt` never exceeds `MAX_BEATS-1`, so it does not wrap.

## Test plan
- Reset with inputs active → all outputs 0. `grant`=4'b0100 on first edge after release → `owner`=2, `src_ready`=4'b0100 one cycle later.
- Requester 1 sends 3 beats 0xA1, 0xA2, 0xA3 with `src_last` on the third, `bus_ready`=1 → `bus_data` sequence A1, A2, A3 on consecutive cycles, `bus_id`=1, `bus_last` only on A3, single `release` pulse after.
- Requester 0 streams 6 beats without `src_last`, MAX_BEATS=4 → 4 beats output, fourth has `bus_last`=1, `release` pulses, beats 5-6 wait for the next grant.
- `bus_ready` toggling 1,0,0,1 mid-burst → `bus_data` holds during stall, no beat lost or duplicated, `src_ready[owner]` low while stalled.
- `grant`=4'b0110 in IDLE → `err_multi` one-cycle pulse, stay IDLE, `src_ready`=0.
- `grant` changes to 4'b1000 during requester-2 XFER → ignored. `reset_n` low mid-burst → `bus_valid`=0 immediately, no `release` pulse.

Source files
------------

// File: rtl/grant_bus_mux_if.sv
// Handshake bundle between the arbiter/requesters, the grant mux and the downstream bus.
// "release" is a reserved word in SystemVerilog, so the ownership-end pulse is named release_pulse.
interface grant_bus_mux_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          grant;
    logic [3:0]          src_valid;
    logic [4*DATA_W-1:0] src_data;
    logic [3:0]          src_last;
    logic [3:0]          src_ready;
    logic                bus_valid;
    logic [DATA_W-1:0]   bus_data;
    logic [1:0]          bus_id;
    logic                bus_last;
    logic                bus_ready;
    logic                release_pulse;
    logic                err_multi;

    // master: the mux itself, which drives src_ready and the output bus
    modport master (
        input  grant, src_valid, src_data, src_last, bus_ready,
        output src_ready, bus_valid, bus_data, bus_id, bus_last, release_pulse, err_multi
    );

    // slave: the surrounding environment (arbiter, requesters, downstream consumer)
    modport slave (
        output grant, src_valid, src_data, src_last, bus_ready,
        input  src_ready, bus_valid, bus_data, bus_id, bus_last, release_pulse, err_multi
    );
endinterface

// File: rtl/grant_bus_mux.sv
// Latches a one-hot arbiter grant as bus owner and forwards that requester's beats
// through a single registered output stage until its last beat (or the beat limit) drains.
module grant_bus_mux #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    grant_bus_mux_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_owner;
    logic [7:0]        r_beat_cnt;
    logic              r_bus_valid;
    logic [DATA_W-1:0] r_bus_data;
    logic [1:0]        r_bus_id;
    logic              r_bus_last;
    logic              r_release;
    logic              r_err_multi;

    logic [DATA_W-1:0] w_src_word [4];
    logic [1:0]        w_grant_idx;
    logic [2:0]        w_grant_cnt;
    logic              w_take;
    logic              w_accept;
    logic              w_last_beat;
    logic [3:0]        w_src_ready;

    for (genvar gi = 0; gi < 4; gi++) begin : g_src_word
        assign w_src_word[gi] = bus.src_data[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        w_grant_idx = 2'd0;
        w_grant_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.grant[i]) begin
                w_grant_idx = 2'(i);
                w_grant_cnt = w_grant_cnt + 3'd1;
            end
        end
    end

    // The output stage can take a beat when empty or when its current beat leaves this cycle.
    assign w_take      = !r_bus_valid || bus.bus_ready;
    assign w_src_ready = (r_state == S_XFER && w_take) ? (4'b0001 << r_owner) : 4'b0000;
    assign w_accept    = (r_state == S_XFER) && w_take && bus.src_valid[r_owner];
    assign w_last_beat = bus.src_last[r_owner] || (r_beat_cnt == 8'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner     <= 2'd0;
            r_beat_cnt  <= 8'd0;
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_bus_id    <= 2'd0;
            r_bus_last  <= 1'b0;
            r_release   <= 1'b0;
            r_err_multi <= 1'b0;
        end else begin
            r_release   <= 1'b0;
            r_err_multi <= 1'b0;

            if (w_accept) begin
                r_bus_valid <= 1'b1;
                r_bus_data  <= w_src_word[r_owner];
                r_bus_id    <= r_owner;
                r_bus_last  <= w_last_beat;
            end else if (r_bus_valid && bus.bus_ready) begin
                r_bus_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_cnt == 3'd1) begin
                        r_owner    <= w_grant_idx;
                        r_beat_cnt <= 8'd0;
                        r_state    <= S_XFER;
                    end else if (w_grant_cnt > 3'd1) begin
                        r_err_multi <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        // Counter stops at the final beat so it never exceeds MAX_BEATS-1.
                        if (w_last_beat) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_bus_valid && bus.bus_ready) begin
                        r_release <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.src_ready     = w_src_ready;
    assign bus.bus_valid     = r_bus_valid;
    assign bus.bus_data      = r_bus_data;
    assign bus.bus_id        = r_bus_id;
    assign bus.bus_last      = r_bus_last;
    assign bus.release_pulse = r_release;
    assign bus.err_multi     = r_err_multi;
endmodule

// File: tb/tb_grant_bus_mux.sv
// Randomized bench for grant_bus_mux: requesters stream queued beats, a burst-level
// reference model predicts every output beat, release pulse and error pulse.
module tb_grant_bus_mux;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;
    localparam int NB        = 40;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
        logic       last;
    } out_t;

    logic clk;
    logic reset_n;

    grant_bus_mux_if #(.DATA_W(DATA_W)) bif ();

    grant_bus_mux #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    beat_t      src_q [4][$];
    int         drv_ptr [4];
    int         mdl_ptr [4];
    out_t       exp_q [$];
    int         n_checks;
    int         n_fail;
    int         rel_count;
    bit         rel_seen;
    logic       exp_err;
    logic [3:0] grant_drive;
    logic [3:0] rel_grant;
    logic [3:0] own_mask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: an ownership takes beats from the requester's stream up to and
    // including the first marked last beat, or MAX_BEATS beats, whichever comes first.
    task automatic plan(input int r, output int n);
        int    i;
        bit    done;
        beat_t bt;
        out_t  e;
        i    = mdl_ptr[r];
        n    = 0;
        done = 0;
        while (!done) begin
            if (i >= src_q[r].size()) begin
                bt.data = 8'($urandom);
                bt.last = ($urandom_range(3) == 0);
                src_q[r].push_back(bt);
            end
            bt     = src_q[r][i];
            e.data = bt.data;
            e.id   = 2'(r);
            e.last = bt.last || (n == MAX_BEATS - 1);
            exp_q.push_back(e);
            done = e.last;
            i++;
            n++;
        end
        mdl_ptr[r] = i;
    endtask

    task automatic step();
        logic [3:0] acc;
        out_t       e;
        @(negedge clk);
        bif.grant = grant_drive;
        for (int i = 0; i < 4; i++) begin
            if (drv_ptr[i] < src_q[i].size()) begin
                bif.src_valid[i]                 = ($urandom_range(3) != 0);
                bif.src_data[i*DATA_W +: DATA_W] = src_q[i][drv_ptr[i]].data;
                bif.src_last[i]                  = src_q[i][drv_ptr[i]].last;
            end else begin
                bif.src_valid[i]                 = 1'b0;
                bif.src_data[i*DATA_W +: DATA_W] = 8'($urandom);
                bif.src_last[i]                  = 1'($urandom);
            end
        end
        bif.bus_ready = ($urandom_range(2) != 0);
        #1;
        check_eq("src_ready_owner", 32'(bif.src_ready & ~own_mask), 32'(0));
        if (bif.bus_valid && !bif.bus_ready)
            check_eq("src_ready_stall", 32'(bif.src_ready), 32'(0));
        check_eq("err_multi", 32'(bif.err_multi), 32'(exp_err));
        if (bif.bus_valid && bif.bus_ready) begin
            check_eq("beat_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("beat id=%0d data=%02h last=%0d (exp id=%0d data=%02h last=%0d)",
                         bif.bus_id, bif.bus_data, bif.bus_last, e.id, e.data, e.last);
                check_eq("bus_data", 32'(bif.bus_data), 32'(e.data));
                check_eq("bus_id", 32'(bif.bus_id), 32'(e.id));
                check_eq("bus_last", 32'(bif.bus_last), 32'(e.last));
            end
        end
        acc = bif.src_valid & bif.src_ready;
        if (bif.release_pulse) begin
            check_eq("src_ready_release", 32'(bif.src_ready), 32'(0));
            check_eq("bus_valid_release", 32'(bif.bus_valid), 32'(0));
            rel_seen = 1;
            rel_count++;
            bif.grant = rel_grant;
        end
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (acc[i]) drv_ptr[i]++;
    endtask

    function automatic int pick(input int b);
        int dir [4] = '{1, 0, 2, 0};
        return (b < 4) ? dir[b] : int'($urandom_range(3));
    endfunction

    initial begin
        int    r;
        int    nr;
        int    len;
        int    nlen;
        int    cyc;
        bit    aborted;
        beat_t bt;

        n_checks  = 0;
        n_fail    = 0;
        rel_count = 0;
        rel_seen  = 0;
        exp_err   = 1'b0;
        own_mask  = 4'b0000;
        rel_grant = 4'b0000;
        aborted   = 0;
        for (int i = 0; i < 4; i++) begin
            drv_ptr[i] = 0;
            mdl_ptr[i] = 0;
        end

        // Reset with every input active
        reset_n       = 1'b0;
        bif.grant     = 4'b0010;
        bif.src_valid = 4'hF;
        bif.src_data  = 32'($urandom);
        bif.src_last  = 4'hF;
        bif.bus_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_src_ready", 32'(bif.src_ready), 32'(0));
        check_eq("rst_bus_valid", 32'(bif.bus_valid), 32'(0));
        check_eq("rst_bus_data", 32'(bif.bus_data), 32'(0));
        check_eq("rst_bus_id", 32'(bif.bus_id), 32'(0));
        check_eq("rst_bus_last", 32'(bif.bus_last), 32'(0));
        check_eq("rst_release", 32'(bif.release_pulse), 32'(0));
        check_eq("rst_err_multi", 32'(bif.err_multi), 32'(0));
        reset_n   = 1'b1;
        bif.grant = 4'b0000;

        // Directed streams: requester 1 short burst, requester 0 overlong burst
        for (int k = 1; k <= 3; k++) begin
            bt.data = 8'hA0 + 8'(k);
            bt.last = (k == 3);
            src_q[1].push_back(bt);
        end
        for (int k = 1; k <= 6; k++) begin
            bt.data = 8'(k);
            bt.last = 1'b0;
            src_q[0].push_back(bt);
        end

        // Multi-hot grant in IDLE
        grant_drive = 4'b0110;
        step();
        grant_drive = 4'b0000;
        exp_err     = 1'b1;
        step();
        exp_err     = 1'b0;
        step();

        r = pick(0);
        plan(r, len);
        grant_drive = 4'b0001 << r;
        step();
        own_mask = 4'b0001 << r;

        for (int b = 0; b < NB && !aborted; b++) begin
            if (b < NB - 1) begin
                nr = pick(b + 1);
                plan(nr, nlen);
                rel_grant = ((b == 1) || ($urandom_range(1) == 0)) ? (4'b0001 << nr) : 4'b0000;
            end else begin
                nr        = 0;
                nlen      = 0;
                rel_grant = 4'b0000;
            end
            rel_seen = 0;
            cyc      = 0;
            while (!rel_seen && cyc < 200) begin
                grant_drive = 4'($urandom);
                step();
                cyc++;
            end
            check_eq("release_seen", 32'(rel_seen), 32'(1));
            if (!rel_seen) begin
                aborted = 1;
            end else begin
                check_eq("beats_left_after_release", 32'(exp_q.size()), 32'(nlen));
                own_mask = 4'b0000;
                if (b < NB - 1) begin
                    if (rel_grant == 4'b0000) begin
                        grant_drive = 4'b0000;
                        repeat ($urandom_range(2)) step();
                        grant_drive = 4'b0001 << nr;
                        step();
                    end
                    own_mask = 4'b0001 << nr;
                end
            end
        end
        check_eq("release_count", 32'(rel_count), 32'(NB));

        if (!aborted) begin
            // Reset in the middle of a requester-2 ownership
            exp_q.delete();
            plan(2, len);
            grant_drive = 4'b0100;
            step();
            own_mask = 4'b0100;
            for (int k = 0; k < 2; k++) begin
                grant_drive = 4'b1000;
                step();
            end
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            check_eq("midrst_bus_valid", 32'(bif.bus_valid), 32'(0));
            check_eq("midrst_src_ready", 32'(bif.src_ready), 32'(0));
            check_eq("midrst_release", 32'(bif.release_pulse), 32'(0));
            repeat (2) begin
                @(negedge clk);
                check_eq("midrst_no_release", 32'(bif.release_pulse), 32'(0));
                check_eq("midrst_bus_valid_hold", 32'(bif.bus_valid), 32'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
